fifo_wr_arbiter: RTL

//  Round-robin, frame-granular arbiter that shares one fifo write port between NUM_REQ

---
 rtl/fifo_wr_arbiter_if.sv | 11 +
 rtl/fifo_wr_arbiter.sv | 128 ++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// Write side of the shared FIFO: one word per cycle when wr_en is set, back-pressured by full.
interface fifo_wr_if #(
  parameter int DATA_W = 32
);
  logic              wr_en;
  logic [DATA_W+1:0] data;
  logic              full;

  modport master (output wr_en, output data, input full);
  modport slave  (input wr_en, input data, output full);
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Frame-granular round-robin arbiter sharing one FIFO write port between NUM_REQ streams.
// state  | meaning
// IDLE   | searching req_valid for the next owner, nothing written
// LOCKED | owner g streams its frame until the last beat is accepted
// ABORT  | owner stalled too long; closing the frame with an abort word
module fifo_wr_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_W        = 32,
  parameter int STALL_TIMEOUT = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  fifo_wr_if.master                  wr_if,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       abort_pulse
);

  localparam int GW    = $clog2(NUM_REQ);
  localparam int CNT_W = (STALL_TIMEOUT > 0) ? $clog2(STALL_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_M1 = CNT_W'((STALL_TIMEOUT > 0) ? STALL_TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, LOCKED, ABORT} state_t;

  state_t            state_q, state_d;
  logic [GW-1:0]     g_q, g_d;
  logic [GW-1:0]     rr_q, rr_d;
  logic [CNT_W-1:0]  stall_q, stall_d;

  logic              found;
  logic [GW-1:0]     pick;
  logic [GW-1:0]     idx;
  logic              g_valid, g_last;
  logic [DATA_W-1:0] g_data;
  logic              wr_en_c;
  logic [DATA_W+1:0] wr_data_c;
  logic              abort_c;

  assign g_valid = req_valid[g_q];
  assign g_last  = req_last[g_q];
  assign g_data  = req_data[int'(g_q)*DATA_W +: DATA_W];

  // Rotating search starting just after the last served requester.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = GW'((int'(rr_q) + k) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    g_d       = g_q;
    rr_d      = rr_q;
    stall_d   = stall_q;
    req_ready = '0;
    wr_en_c   = 1'b0;
    wr_data_c = '0;
    abort_c   = 1'b0;
    case (state_q)
      IDLE: begin
        stall_d = '0;
        if (found) begin
          g_d     = pick;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        req_ready[g_q] = !wr_if.full;
        wr_en_c        = g_valid && !wr_if.full;
        wr_data_c      = {1'b0, g_last, g_data};
        // Only an absent owner counts as a stall; back-pressure does not.
        if (g_valid)
          stall_d = '0;
        else if (stall_q != '1)
          stall_d = stall_q + CNT_W'(1);
        if (wr_en_c && g_last) begin
          rr_d    = g_q;
          state_d = IDLE;
        end else if (STALL_TIMEOUT != 0 && !g_valid && stall_q == TO_M1) begin
          state_d = ABORT;
        end
      end
      ABORT: begin
        wr_en_c   = !wr_if.full;
        wr_data_c = {2'b11, {DATA_W{1'b0}}};
        abort_c   = wr_en_c;
        if (wr_en_c) begin
          rr_d    = g_q;
          stall_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      g_q     <= '0;
      rr_q    <= GW'(NUM_REQ - 1);
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      rr_q    <= rr_d;
      stall_q <= stall_d;
    end
  end

  assign wr_if.wr_en = wr_en_c;
  assign wr_if.data  = wr_data_c;
  assign grant_id    = g_q;
  assign busy        = (state_q != IDLE);
  assign abort_pulse = abort_c;

endmodule
